// File: rtl/fly_wave_scheduler.sv
// Fly enemy wave sequencer: spawns one fly per slot over valid/ready, paces descent with
// move_tick, tracks live slots from hit pulses and restarts each cleared wave at a faster pace.
module fly_wave_scheduler #(
  parameter int unsigned FLY_COUNT   = 4,
  parameter int unsigned X_BASE      = 200,
  parameter int unsigned X_STEP      = 50,
  parameter int unsigned SPAWN_GAP   = 16,
  parameter int unsigned WAVE_DELAY  = 1000,
  parameter int unsigned BASE_PERIOD = 524288,
  parameter int unsigned PERIOD_STEP = 65536,
  parameter int unsigned MIN_PERIOD  = 131072,
  parameter int unsigned MAX_WAVE    = 15
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FLY_COUNT-1:0] fly_hit,
  input  logic                 spawn_ready,
  output logic                 spawn_valid,
  output logic [2:0]           spawn_idx,
  output logic [9:0]           spawn_x,
  output logic [9:0]           spawn_y,
  output logic                 move_tick,
  output logic [FLY_COUNT-1:0] alive_mask,
  output logic [3:0]           wave_num,
  output logic                 wave_clear
);

  localparam int GAP_W   = $clog2(SPAWN_GAP + 1);
  localparam int DELAY_W = $clog2(WAVE_DELAY + 1);

  typedef enum logic [1:0] {IDLE, SPAWN, ACTIVE, CLEAR_WAIT} state_t;

  state_t               state;
  logic [2:0]           slot;
  logic [19:0]          period;
  logic [19:0]          tick_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [DELAY_W-1:0]   delay_cnt;

  logic                 xfer;
  logic [FLY_COUNT-1:0] mask_next;
  logic [3:0]           wave_next;
  logic [20:0]          period_diff;
  logic [19:0]          period_next;

  // Each wave shifts the column right by 8 px per wave, wrapping every 8 waves.
  function automatic logic [9:0] x_of(input logic [2:0] s, input logic [3:0] w);
    int unsigned x;
    x = X_BASE + 32'(s) * X_STEP + 32'(w[2:0]) * 8;
    return x[9:0];
  endfunction

  assign xfer      = spawn_valid && spawn_ready;
  assign spawn_idx = slot;
  assign spawn_y   = '0;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mask_next = alive_mask & ~fly_hit;
    // A transfer on the same slot as a hit re-arms that slot.
    if (xfer) mask_next = mask_next | (FLY_COUNT'(1) << slot);
  end

  assign wave_next   = (wave_num >= 4'(MAX_WAVE)) ? wave_num : wave_num + 4'd1;
  // Widened by one bit so the borrow of an underflowing subtract is visible.
  assign period_diff = {1'b0, period} - 21'(PERIOD_STEP);
  assign period_next = (period_diff[20] || period_diff[19:0] < 20'(MIN_PERIOD))
                     ? 20'(MIN_PERIOD) : period_diff[19:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      period      <= '0;
      tick_cnt    <= '0;
      gap_cnt     <= '0;
      delay_cnt   <= '0;
      spawn_valid <= 1'b0;
      spawn_x     <= '0;
      move_tick   <= 1'b0;
      alive_mask  <= '0;
      wave_num    <= '0;
      wave_clear  <= 1'b0;
    end else begin
      move_tick  <= 1'b0;
      wave_clear <= 1'b0;

      if (state == SPAWN || state == ACTIVE) begin
        alive_mask <= mask_next;
        if (tick_cnt == period - 20'd1) begin
          move_tick <= 1'b1;
          tick_cnt  <= '0;
        end else begin
          tick_cnt <= tick_cnt + 20'd1;
        end
      end else begin
        tick_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= SPAWN;
            wave_num    <= 4'd1;
            period      <= 20'(BASE_PERIOD);
            slot        <= '0;
            spawn_valid <= 1'b1;
            spawn_x     <= x_of(3'd0, 4'd1);
          end
        end
        SPAWN: begin
          if (spawn_valid) begin
            if (spawn_ready) begin
              spawn_valid <= 1'b0;
              if (slot == 3'(FLY_COUNT - 1)) begin
                state <= ACTIVE;
              end else begin
                slot    <= slot + 3'd1;
                gap_cnt <= GAP_W'(SPAWN_GAP);
              end
            end
          end else if (gap_cnt <= GAP_W'(1)) begin
            spawn_valid <= 1'b1;
            spawn_x     <= x_of(slot, wave_num);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ACTIVE: begin
          if (alive_mask == '0) begin
            wave_clear <= 1'b1;
            delay_cnt  <= '0;
            state      <= CLEAR_WAIT;
          end
        end
        CLEAR_WAIT: begin
          if (delay_cnt == DELAY_W'(WAVE_DELAY - 1)) begin
            wave_num    <= wave_next;
            period      <= period_next;
            slot        <= '0;
            spawn_valid <= 1'b1;
            spawn_x     <= x_of(3'd0, wave_next);
            state       <= SPAWN;
          end else begin
            delay_cnt <= delay_cnt + DELAY_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
